prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter width.
REQ-002 SHALL have parameter OFF_W, default 5, signed branch-offset width (OFF_W < PC_W).
REQ-003 SHALL have parameter STACK_D, default 4, return-stack depth (>= 1).
REQ-004 SHALL have parameter CYC_W, default 16, cycle-counter width.
REQ-005 SHALL have port Clk  input  1  clock; all state changes on posedge.
REQ-006 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port Start  input  1  launch request, rising-edge detected.
REQ-008 SHALL have port Stall  input  1  hold PC this cycle.
REQ-009 SHALL have port Halt  input  1  decoded halt instruction.
REQ-010 SHALL have port BranchEn  input  1  decoded branch.
REQ-011 SHALL have port ConditionBranch  input  1  branch taken only if GE_Flag.
REQ-012 SHALL have port GE_Flag  input  1  greater-or-equal flag.
REQ-013 SHALL have port Call  input  1  decoded call; Return  input  1  decoded return.
REQ-014 SHALL have port BranchOffset  input  OFF_W  two's-complement PC-relative offset.
REQ-015 SHALL have port ProgCtr  output  PC_W  current instruction address.
REQ-016 SHALL have ports Ack  output  1  done; Busy  output  1  running; StackErr  output  1  stack fault; CycleCt  output  CYC_W  cycles run.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; Busy=1 only in RUN, Ack=1 only in DONE.
REQ-018 SHALL register Start and define launch as Start=1 with previous-cycle Start=0.
REQ-019 On launch in IDLE or DONE, SHALL next cycle enter RUN with ProgCtr=0, SP=0, StackErr=0, CycleCt=0.
REQ-020 SHALL ignore launch while in RUN.
REQ-021 In RUN with Stall=1, SHALL hold ProgCtr and SP and ignore Halt/Call/Return/BranchEn.
REQ-022 In RUN with Stall=0, SHALL apply priority Halt > Return > Call > BranchEn > increment.
REQ-023 Halt: SHALL enter DONE next cycle, ProgCtr held.
REQ-024 Branch: taken when ConditionBranch=0 or GE_Flag=1; taken -> ProgCtr+signext(BranchOffset), else ProgCtr+1.
REQ-025 Call: SHALL push ProgCtr+1, SP+1, and load ProgCtr+signext(BranchOffset).
REQ-026 Return: SHALL pop top entry into ProgCtr, SP-1.
REQ-027 Call with SP=STACK_D or Return with SP=0: SHALL set StackErr=1, enter DONE, leave ProgCtr and SP unchanged.
REQ-028 All PC arithmetic SHALL be modulo 2^PC_W (wrap, no flag).
REQ-029 Default increment SHALL be ProgCtr+1 with wrap from 2^PC_W-1 to 0.
REQ-030 CycleCt SHALL increment every RUN cycle including stalled ones, saturate at all-ones, hold in IDLE/DONE.
REQ-031 StackErr and Ack SHALL hold in DONE until next launch.

Reset
REQ-032 Reset_n=0 SHALL immediately force IDLE, ProgCtr=0, SP=0, Ack=0, Busy=0, StackErr=0, CycleCt=0, registered Start=0.
REQ-033 Reset mid-RUN SHALL abandon execution; stack contents need not be cleared.
REQ-034 Launch SHALL require a Start rising edge after Reset_n deasserts.

Configuration
REQ-035 With SEQ_CYCLE_COUNT_EN defined, SHALL implement CycleCt per REQ-030.
REQ-036 Without SEQ_CYCLE_COUNT_EN, CycleCt SHALL be constant 0 and counter logic absent.

Verification
REQ-037 Launch, 5 plain cycles, Halt -> ProgCtr 0..5, Ack=1 next cycle, CycleCt=6, Busy=0.
REQ-038 At PC=3, BranchEn, ConditionBranch=1, GE_Flag=0, offset 5'b11110 -> PC=4; GE_Flag=1 -> PC=1.
REQ-039 Call at PC=2 offset +6 -> PC=8; Return at PC=9 -> PC=3, SP back to 0.
REQ-040 STACK_D=4: five nested Calls -> 5th sets StackErr=1, Ack=1, PC unchanged; Return at SP=0 -> same.
REQ-041 PC=1023, increment -> PC=0; Stall held 3 cycles -> PC constant, CycleCt +3.
REQ-042 Reset_n low mid-RUN -> all outputs 0 asynchronously; Start held high across reset -> no launch until low-then-high.

Source files
------------

// File: rtl/prog_sequencer.sv
// prog_sequencer: program-counter sequencer with IDLE/RUN/DONE control,
// relative branches, call/return stack, stack-fault detection and an
// optional saturating cycle counter (enabled by `define SEQ_CYCLE_COUNT_EN).
//
// Ports:
//   Clk, Reset_n        clock, asynchronous active-low reset
//   Start               launch request (rising edge, must follow a low after reset)
//   Stall               hold PC/SP this cycle
//   Halt, BranchEn,
//   ConditionBranch,
//   GE_Flag, Call,
//   Return              decoded instruction controls
//   BranchOffset        signed PC-relative offset (OFF_W bits)
//   ProgCtr             current instruction address (PC_W bits)
//   Ack / Busy          DONE / RUN indicators
//   StackErr            call overflow or return underflow seen
//   CycleCt             RUN cycles since launch (0 when counter disabled)
module prog_sequencer #(
    parameter int PC_W    = 10,
    parameter int OFF_W   = 5,
    parameter int STACK_D = 4,
    parameter int CYC_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic             ConditionBranch,
    input  logic             GE_Flag,
    input  logic             Call,
    input  logic             Return,
    input  logic [OFF_W-1:0] BranchOffset,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Ack,
    output logic             Busy,
    output logic             StackErr,
    output logic [CYC_W-1:0] CycleCt
);

    localparam int SP_W = $clog2(STACK_D + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             start_q, start_d;
    logic             armed_q, armed_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic             err_q, err_d;
    logic [PC_W-1:0]  stack_q [STACK_D];

    logic             launch;
    logic             run_step;
    logic             do_halt, do_ret, do_call, do_br, do_inc;
    logic             stack_full, stack_empty;
    logic             ret_err, call_err, push_en;
    logic             br_taken;
    logic [PC_W-1:0]  pc_inc, pc_rel, off_ext, pop_data;
    logic [SP_W-1:0]  sp_dec, sp_inc;

    // armed_q only rises once Start has been seen low, so a Start held
    // high through reset cannot launch on its own.
    assign launch = Start & ~start_q & armed_q;

    assign start_d = Start;
    assign armed_d = armed_q | ~Start;

    assign run_step = (state_q == S_RUN) & ~Stall;
    assign do_halt  = run_step & Halt;
    assign do_ret   = run_step & ~Halt & Return;
    assign do_call  = run_step & ~Halt & ~Return & Call;
    assign do_br    = run_step & ~Halt & ~Return & ~Call & BranchEn;
    assign do_inc   = run_step & ~(Halt | Return | Call | BranchEn);

    assign stack_full  = (sp_q == SP_W'(STACK_D));
    assign stack_empty = (sp_q == '0);
    assign ret_err     = do_ret & stack_empty;
    assign call_err    = do_call & stack_full;
    assign push_en     = do_call & ~stack_full;

    assign br_taken = ~ConditionBranch | GE_Flag;
    assign off_ext  = {{(PC_W-OFF_W){BranchOffset[OFF_W-1]}}, BranchOffset};
    assign pc_inc   = pc_q + PC_W'(1);
    assign pc_rel   = pc_q + off_ext;
    assign sp_dec   = sp_q - SP_W'(1);
    assign sp_inc   = sp_q + SP_W'(1);

    always_comb begin
        pop_data = '0;
        for (int i = 0; i < STACK_D; i++) begin
            if (sp_dec == SP_W'(i)) begin
                pop_data = stack_q[i];
            end
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            armed_q <= 1'b0;
            pc_q    <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            armed_q <= armed_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Stack storage is not reset; SP alone defines which entries are live.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < STACK_D; i++) begin
            if (push_en && (sp_q == SP_W'(i))) begin
                stack_q[i] <= pc_inc;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (launch) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (do_halt | ret_err | call_err) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // PC / SP / fault datapath; the do_* strobes are mutually exclusive.
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        err_d = err_q;
        if ((state_q != S_RUN) && launch) begin
            pc_d  = '0;
            sp_d  = '0;
            err_d = 1'b0;
        end else begin
            unique case (1'b1)
                do_halt: begin
                    pc_d = pc_q;
                end
                do_ret: begin
                    if (stack_empty) begin
                        err_d = 1'b1;
                    end else begin
                        pc_d = pop_data;
                        sp_d = sp_dec;
                    end
                end
                do_call: begin
                    if (stack_full) begin
                        err_d = 1'b1;
                    end else begin
                        pc_d = pc_rel;
                        sp_d = sp_inc;
                    end
                end
                do_br: begin
                    pc_d = br_taken ? pc_rel : pc_inc;
                end
                do_inc: begin
                    pc_d = pc_inc;
                end
                default: begin
                    pc_d = pc_q;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        Busy     = (state_q == S_RUN);
        Ack      = (state_q == S_DONE);
        StackErr = err_q;
        ProgCtr  = pc_q;
    end

`ifdef SEQ_CYCLE_COUNT_EN
    logic [CYC_W-1:0] cyc_q, cyc_d;

    // Counts every RUN cycle, stalled or not, and saturates at all-ones.
    always_comb begin
        cyc_d = cyc_q;
        if ((state_q != S_RUN) && launch) begin
            cyc_d = '0;
        end else if ((state_q == S_RUN) && !(&cyc_q)) begin
            cyc_d = cyc_q + CYC_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign CycleCt = cyc_q;
`else
    assign CycleCt = '0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed vector table plus hand sequences for
// async reset, held-Start relaunch and a small-parameter instance.
module tb_prog_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic       Stall = 1'b0;
    logic       Halt = 1'b0;
    logic       BranchEn = 1'b0;
    logic       ConditionBranch = 1'b0;
    logic       GE_Flag = 1'b0;
    logic       Call = 1'b0;
    logic       Return = 1'b0;
    logic [4:0] BranchOffset = '0;

    logic [9:0]  ProgCtr;
    logic        Ack, Busy, StackErr;
    logic [15:0] CycleCt;

    logic [3:0]  s_pc;
    logic        s_ack, s_busy, s_err;
    logic [1:0]  s_cyc;

    int n_vec = 0;
    int n_bad = 0;

`ifdef SEQ_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    prog_sequencer u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
        .Halt(Halt), .BranchEn(BranchEn),
        .ConditionBranch(ConditionBranch), .GE_Flag(GE_Flag),
        .Call(Call), .Return(Return), .BranchOffset(BranchOffset),
        .ProgCtr(ProgCtr), .Ack(Ack), .Busy(Busy),
        .StackErr(StackErr), .CycleCt(CycleCt)
    );

    prog_sequencer #(
        .PC_W(4), .OFF_W(3), .STACK_D(2), .CYC_W(2)
    ) u_small (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
        .Halt(Halt), .BranchEn(BranchEn),
        .ConditionBranch(ConditionBranch), .GE_Flag(GE_Flag),
        .Call(Call), .Return(Return), .BranchOffset(BranchOffset[2:0]),
        .ProgCtr(s_pc), .Ack(s_ack), .Busy(s_busy),
        .StackErr(s_err), .CycleCt(s_cyc)
    );

    always #5 Clk = ~Clk;

    // control bits {Start,Stall,Halt,BranchEn,ConditionBranch,GE_Flag,Call,Return}
    localparam logic [7:0] ST  = 8'h80;
    localparam logic [7:0] STL = 8'h40;
    localparam logic [7:0] HLT = 8'h20;
    localparam logic [7:0] BR  = 8'h10;
    localparam logic [7:0] CND = 8'h08;
    localparam logic [7:0] GE  = 8'h04;
    localparam logic [7:0] CAL = 8'h02;
    localparam logic [7:0] RET = 8'h01;
    // status {Busy,Ack,StackErr}
    localparam logic [2:0] IDL = 3'b000;
    localparam logic [2:0] RUN = 3'b100;
    localparam logic [2:0] DN  = 3'b010;
    localparam logic [2:0] DNE = 3'b011;

    typedef struct {
        logic [7:0]  ctl;
        logic [4:0]  off;
        logic [9:0]  pc;
        logic [2:0]  sts;
        logic [15:0] cyc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic [7:0] c, input logic [4:0] o,
                                input int pc, input logic [2:0] s,
                                input int cyc);
        vec_t v;
        v.ctl = c;
        v.off = o;
        v.pc  = 10'(pc);
        v.sts = s;
        v.cyc = 16'(cyc);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [9:0] pc,
                       input logic [2:0] s, input logic [15:0] cyc);
        logic [15:0] ec;
        ec = CNT_EN ? cyc : 16'd0;
        n_vec++;
        if (ProgCtr !== pc || {Busy, Ack, StackErr} !== s || CycleCt !== ec) begin
            n_bad++;
            $display("FAIL %s: got pc=%0d busy/ack/err=%b cyc=%0d, want pc=%0d busy/ack/err=%b cyc=%0d",
                     nm, ProgCtr, {Busy, Ack, StackErr}, CycleCt, pc, s, ec);
        end
    endtask

    task automatic chks(input string nm, input logic [3:0] pc,
                        input logic [2:0] s, input logic [1:0] cyc);
        logic [1:0] ec;
        ec = CNT_EN ? cyc : 2'd0;
        n_vec++;
        if (s_pc !== pc || {s_busy, s_ack, s_err} !== s || s_cyc !== ec) begin
            n_bad++;
            $display("FAIL %s: got pc=%0d busy/ack/err=%b cyc=%0d, want pc=%0d busy/ack/err=%b cyc=%0d",
                     nm, s_pc, {s_busy, s_ack, s_err}, s_cyc, pc, s, ec);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        {Start, Stall, Halt, BranchEn, ConditionBranch, GE_Flag, Call, Return} = v.ctl;
        BranchOffset = v.off;
        @(posedge Clk);
        #1;
        chk(nm, v.pc, v.sts, v.cyc);
    endtask

    initial begin
        // arm, launch, five plain cycles, halt
        tv.push_back(mk(0, 0, 0, IDL, 0));
        tv.push_back(mk(ST, 0, 0, RUN, 0));
        for (int i = 1; i <= 5; i++) tv.push_back(mk(0, 0, i, RUN, i));
        tv.push_back(mk(HLT, 0, 5, DN, 6));
        tv.push_back(mk(0, 0, 5, DN, 6));
        // conditional branches around PC=3
        tv.push_back(mk(ST, 0, 0, RUN, 0));
        tv.push_back(mk(0, 0, 1, RUN, 1));
        tv.push_back(mk(0, 0, 2, RUN, 2));
        tv.push_back(mk(0, 0, 3, RUN, 3));
        tv.push_back(mk(BR | CND, 5'b11110, 4, RUN, 4));
        tv.push_back(mk(BR, 5'b11111, 3, RUN, 5));
        tv.push_back(mk(BR | CND | GE, 5'b11110, 1, RUN, 6));
        tv.push_back(mk(ST, 0, 2, RUN, 7));
        tv.push_back(mk(0, 0, 3, RUN, 8));
        // call at 2 (+6), return at 9, then underflow
        tv.push_back(mk(BR, 5'b11111, 2, RUN, 9));
        tv.push_back(mk(CAL, 5'd6, 8, RUN, 10));
        tv.push_back(mk(0, 0, 9, RUN, 11));
        tv.push_back(mk(RET, 0, 3, RUN, 12));
        tv.push_back(mk(RET, 0, 3, DNE, 13));
        tv.push_back(mk(0, 0, 3, DNE, 13));
        // overflow on the fifth nested call
        tv.push_back(mk(ST, 0, 0, RUN, 0));
        tv.push_back(mk(CAL, 5'd2, 2, RUN, 1));
        tv.push_back(mk(CAL, 5'd2, 4, RUN, 2));
        tv.push_back(mk(CAL, 5'd2, 6, RUN, 3));
        tv.push_back(mk(CAL, 5'd2, 8, RUN, 4));
        tv.push_back(mk(CAL, 5'd2, 8, DNE, 5));
        // priority and stall
        tv.push_back(mk(ST, 0, 0, RUN, 0));
        tv.push_back(mk(CAL | BR, 5'd4, 4, RUN, 1));
        tv.push_back(mk(RET | CAL | BR, 5'd3, 1, RUN, 2));
        tv.push_back(mk(STL | HLT | CAL, 0, 1, RUN, 3));
        tv.push_back(mk(STL, 0, 1, RUN, 4));
        tv.push_back(mk(STL | RET, 0, 1, RUN, 5));
        tv.push_back(mk(HLT | RET, 0, 1, DN, 6));
        // PC wrap 1023 -> 0
        tv.push_back(mk(ST, 0, 0, RUN, 0));
        tv.push_back(mk(BR, 5'b11111, 1023, RUN, 1));
        tv.push_back(mk(0, 0, 0, RUN, 2));
        tv.push_back(mk(BR | CND | GE, 5'd1, 1, RUN, 3));
        tv.push_back(mk(HLT, 0, 1, DN, 4));
        // nested call / return ordering
        tv.push_back(mk(ST, 0, 0, RUN, 0));
        tv.push_back(mk(CAL, 5'd5, 5, RUN, 1));
        tv.push_back(mk(CAL, 5'd5, 10, RUN, 2));
        tv.push_back(mk(RET, 0, 6, RUN, 3));
        tv.push_back(mk(RET, 0, 1, RUN, 4));
        tv.push_back(mk(HLT, 0, 1, DN, 5));

        #12;
        chk("reset_state", 10'd0, IDL, 16'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            apply(tv[i], $sformatf("vec%0d", i));
        end

        // asynchronous reset in the middle of RUN with Start held high
        apply(mk(ST, 0, 0, RUN, 0), "rst_launch");
        apply(mk(0, 0, 1, RUN, 1), "rst_run1");
        #2;
        Start = 1'b1;
        Reset_n = 1'b0;
        #1;
        chk("async_reset", 10'd0, IDL, 16'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        apply(mk(ST, 0, 0, IDL, 0), "held_start0");
        apply(mk(ST, 0, 0, IDL, 0), "held_start1");
        apply(mk(ST, 0, 0, IDL, 0), "held_start2");
        apply(mk(0, 0, 0, IDL, 0), "start_low");
        apply(mk(ST, 0, 0, RUN, 0), "relaunch");
        chks("small_launch", 4'd0, RUN, 2'd0);

        // small instance: CycleCt saturates at 3, STACK_D=2 overflow
        apply(mk(0, 0, 1, RUN, 1), "main_p1");
        apply(mk(0, 0, 2, RUN, 2), "main_p2");
        apply(mk(0, 0, 3, RUN, 3), "main_p3");
        chks("small_sat", 4'd3, RUN, 2'd3);
        apply(mk(0, 0, 4, RUN, 4), "main_p4");
        apply(mk(0, 0, 5, RUN, 5), "main_p5");
        chks("small_hold_sat", 4'd5, RUN, 2'd3);
        apply(mk(CAL, 5'd2, 7, RUN, 6), "main_call1");
        apply(mk(CAL, 5'd2, 9, RUN, 7), "main_call2");
        chks("small_call2", 4'd9, RUN, 2'd3);
        apply(mk(CAL, 5'd2, 11, RUN, 8), "main_call3");
        chks("small_overflow", 4'd9, DNE, 2'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
